axi_burst_addr_gen: RTL and testbench
=====================================

// Module: axi_burst_addr_gen
// PURPOSE
//  Slave-side write/read address sequencer. Consumes one accepted AW or AR command and emits one
//  beat descriptor per data beat: byte address, lane strobe, last flag, error flag. Sits directly
//  downstream of the AXI address channel, feeding the slave memory (4096 B) access logic.
// PARAMETERS
//  WIDTH  32  address width and data-bus width in bits; LEN_W = STRB_W = WIDTH/8
//  SIZE   3   width of the size field; burst field is SIZE-1 bits
// PORTS
//  clk        in   1        clock
//  reset      in   1        synchronous, active-high reset
//  cmd_valid  in   1        command present
//  cmd_ready  out  1        command accepted when cmd_valid && cmd_ready
//  cmd_addr   in   WIDTH    start address
//  cmd_len    in   WIDTH/8  beats minus 1
//  cmd_size   in   SIZE     log2 of bytes per beat
//  cmd_burst  in   SIZE-1   00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  cmd_id     in   WIDTH/8  transaction ID
//  beat_valid out  1        beat descriptor valid
//  beat_ready in   1        consumer takes beat
//  beat_addr  out  WIDTH    byte address of the current beat
//  beat_strb  out  WIDTH/8  active byte lanes
//  beat_last  out  1        final beat of the burst
//  beat_id    out  WIDTH/8  latched cmd_id
//  beat_err   out  1        illegal command; consumer answers SLVERR
// BEHAVIOUR
//  - Reset: state IDLE; cmd_ready, beat_valid, beat_last, beat_err = 0; beat_addr, beat_strb, beat_id = 0.
//    cmd_ready rises on the first cycle after reset deasserts.
//  - FSM IDLE -> BURST on accept.
//    BURST -> IDLE on beat_valid && beat_ready && beat_last.
//    cmd_ready = (state==IDLE) && !reset; no accept while in BURST.
//  - Latency: first beat_valid appears the cycle after accept.
//    Bursts are separated by at least one IDLE cycle.
//  - While beat_valid && !beat_ready, all beat_* outputs hold stable.
//  - Beat count = cmd_len+1. beat_last is asserted when the internal counter == latched len.
//  - bytes = 1<<size.
//  - FIXED: every beat uses the start address.
//  - INCR: next address = (addr & ~(bytes-1)) + bytes. Only the first beat may be unaligned.
//  - WRAP: span = bytes*(len+1); low = addr & ~(span-1); next = addr+bytes; if next == low+span then next = low.
//  - beat_strb: lane i is set iff addr[1:0] <= i < (addr[1:0] & ~(bytes-1)) + bytes.
//  - Error, latched at accept: size > log2(WIDTH/8), burst==11, WRAP with len not in {1,3,7,15},
//    or WRAP with an unaligned start. On error, beat_err=1 on every beat, addresses follow FIXED,
//    and the full len+1 beats are still issued.
//  - Address arithmetic wraps modulo 2^WIDTH.
//  - Reset mid-burst: the burst is abandoned; beat_valid = 0 after the edge; no partial beats resume.
// CONFIGURATION
//  AXI_4K_CHECK_EN defined: an INCR burst whose last byte crosses a 4 KB boundary sets beat_err on
//    all beats, with addresses as FIXED.
//  AXI_4K_CHECK_EN undefined: no boundary check; addresses increment across the boundary.
// STRUCTURE
//  Package axi_pkg: burst_t enum (FIXED/INCR/WRAP/RSVD), resp constants (OKAY=2'b00, SLVERR=2'b10),
//    state_t enum (IDLE/BURST).
//  Sub-module axi_beat_strb: combinational lane mask from addr[1:0] and size.
// TESTING
//  1. INCR 0x100, len 3, size 2 -> 0x100, 0x104, 0x108, 0x10C; strb 1111; last on beat 4; err 0.
//  2. WRAP 0x38, len 3, size 2 -> 0x38, 0x3C, 0x30, 0x34; last on 0x34.
//  3. FIXED 0x20, len 2, size 1 -> 0x20 x3, strb 0011; INCR 0x101, len 1, size 2 -> 0x101/1110, 0x104/1111.
//  4. beat_ready low 3 cycles on beat 2 -> outputs frozen; reset asserted on beat 3 -> beat_valid 0
//     next cycle; cmd_ready 1 the cycle after release.
//  5. burst 11 or WRAP len 2 or size 3 -> len+1 beats, all beat_err=1, constant address.
//  6. INCR 0xFF8, len 3, size 2: with AXI_4K_CHECK_EN -> err 1 on all beats, addr 0xFF8;
//     without -> err 0, addresses 0xFF8, 0xFFC, 0x1000, 0x1004.

Source files
------------

// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared types for the AXI slave-side burst address sequencer.
//   burst_t : AXI burst encoding (FIXED / INCR / WRAP / reserved)
//   state_t : sequencer state (IDLE waiting for a command, BURST issuing beats)
//   OKAY / SLVERR : response codes the downstream consumer uses
// ---------------------------------------------------------------------------
package axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi_beat_strb.sv
// ---------------------------------------------------------------------------
// axi_beat_strb
// Combinational byte-lane mask for one beat.
//   addr_lo : low address bits selecting the first byte lane
//   size    : log2 of bytes per beat
//   strb    : lane i set iff addr_lo <= i < (addr_lo & ~(bytes-1)) + bytes
// An unaligned address keeps the upper end of the beat's aligned window, so
// only the lanes from the start byte to the window end are enabled.
// ---------------------------------------------------------------------------
module axi_beat_strb #(
    parameter int STRB_W = 4,
    parameter int SIZE   = 3
) (
    input  logic [$clog2(STRB_W)-1:0] addr_lo,
    input  logic [SIZE-1:0]           size,
    output logic [STRB_W-1:0]         strb
);

    logic [31:0] lo_s;
    logic [31:0] bytes_s;
    logic [31:0] hi_s;

    // Lane window [lo, hi) for the beat.
    always_comb begin
        lo_s    = 32'(addr_lo);
        bytes_s = 32'd1 << size;
        hi_s    = (lo_s & ~(bytes_s - 32'd1)) + bytes_s;
        strb    = {STRB_W{1'b0}};
        for (int i = 0; i < STRB_W; i++) begin
            strb[i] = (32'(i) >= lo_s) && (32'(i) < hi_s);
        end
    end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// ---------------------------------------------------------------------------
// axi_burst_addr_gen
// Slave-side AW/AR address sequencer: accepts one command and emits one beat
// descriptor (address, strobe, last, error, id) per data beat.
//   clk, reset            : clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake
//   cmd_addr/len/size/burst/id : AXI command fields
//   beat_valid/beat_ready : beat descriptor handshake
//   beat_addr/strb/last/id/err : registered beat descriptor
// Build option: define AXI_4K_CHECK_EN to flag INCR bursts crossing a 4 KB
// boundary as errors (addresses then stay fixed); undefined, no check is made.
// ---------------------------------------------------------------------------
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SIZE  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WIDTH-1:0]     cmd_addr,
    input  logic [WIDTH/8-1:0]   cmd_len,
    input  logic [SIZE-1:0]      cmd_size,
    input  logic [SIZE-2:0]      cmd_burst,
    input  logic [WIDTH/8-1:0]   cmd_id,
    output logic                 beat_valid,
    input  logic                 beat_ready,
    output logic [WIDTH-1:0]     beat_addr,
    output logic [WIDTH/8-1:0]   beat_strb,
    output logic                 beat_last,
    output logic [WIDTH/8-1:0]   beat_id,
    output logic                 beat_err
);

    localparam int LEN_W    = WIDTH / 8;
    localparam int STRB_W   = WIDTH / 8;
    localparam int OFF_W    = $clog2(STRB_W);
    localparam int MAX_SIZE = $clog2(STRB_W);

    state_t               state_r;
    burst_t               mode_r;
    logic [SIZE-1:0]      size_r;
    logic [LEN_W-1:0]     len_r;
    logic [LEN_W-1:0]     cnt_r;
    logic [WIDTH-1:0]     wrap_low_r;
    logic [WIDTH-1:0]     wrap_high_r;

    burst_t               burst_s;
    logic [WIDTH-1:0]     bytes_cmd_s;
    logic [WIDTH-1:0]     span_cmd_s;
    logic                 wrap_len_ok_s;
    logic                 err_s;
    logic                 cross_4k_s;
    logic [WIDTH-1:0]     bytes_r_s;
    logic [WIDTH-1:0]     wrap_step_s;
    logic [WIDTH-1:0]     next_addr_s;
    logic [WIDTH-1:0]     strb_addr_s;
    logic [SIZE-1:0]      strb_size_s;
    logic [STRB_W-1:0]    strb_s;

    // Ready is a direct function of state so it rises the first cycle out of reset.
    assign cmd_ready = (state_r == IDLE) && !reset;

    assign burst_s     = burst_t'(cmd_burst);
    assign bytes_cmd_s = {{(WIDTH-1){1'b0}}, 1'b1} << cmd_size;
    assign span_cmd_s  = ({{(WIDTH-LEN_W){1'b0}}, cmd_len} + {{(WIDTH-1){1'b0}}, 1'b1}) << cmd_size;

    assign wrap_len_ok_s = (cmd_len == LEN_W'(1))  || (cmd_len == LEN_W'(3)) ||
                           (cmd_len == LEN_W'(7))  || (cmd_len == LEN_W'(15));

`ifdef AXI_4K_CHECK_EN
    logic [WIDTH-1:0] incr_last_byte_s;
    // Last byte touched by the burst, measured from the aligned start.
    assign incr_last_byte_s = (cmd_addr & ~(bytes_cmd_s - {{(WIDTH-1){1'b0}}, 1'b1}))
                              + span_cmd_s - {{(WIDTH-1){1'b0}}, 1'b1};
    assign cross_4k_s = (burst_s == INCR) &&
                        (incr_last_byte_s[WIDTH-1:12] != cmd_addr[WIDTH-1:12]);
`else
    assign cross_4k_s = 1'b0;
`endif

    // Illegal-command classification, evaluated on the command being accepted.
    always_comb begin
        err_s = 1'b0;
        if (cmd_size > SIZE'(MAX_SIZE)) begin
            err_s = 1'b1;
        end else if (burst_s == RSVD) begin
            err_s = 1'b1;
        end else if ((burst_s == WRAP) &&
                     (!wrap_len_ok_s ||
                      ((cmd_addr & (bytes_cmd_s - {{(WIDTH-1){1'b0}}, 1'b1})) != {WIDTH{1'b0}}))) begin
            err_s = 1'b1;
        end else if (cross_4k_s) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    // Address of the beat following the one currently presented.
    always_comb begin
        bytes_r_s   = {{(WIDTH-1){1'b0}}, 1'b1} << size_r;
        wrap_step_s = beat_addr + bytes_r_s;
        next_addr_s = beat_addr;
        case (mode_r)
            FIXED:   next_addr_s = beat_addr;
            INCR:    next_addr_s = (beat_addr & ~(bytes_r_s - {{(WIDTH-1){1'b0}}, 1'b1})) + bytes_r_s;
            WRAP:    next_addr_s = (wrap_step_s == wrap_high_r) ? wrap_low_r : wrap_step_s;
            default: next_addr_s = beat_addr;
        endcase
    end

    // One strobe generator serves both the first beat and all following beats.
    always_comb begin
        if (state_r == IDLE) begin
            strb_addr_s = cmd_addr;
            strb_size_s = cmd_size;
        end else begin
            strb_addr_s = next_addr_s;
            strb_size_s = size_r;
        end
    end

    axi_beat_strb #(
        .STRB_W (STRB_W),
        .SIZE   (SIZE)
    ) u_strb (
        .addr_lo (strb_addr_s[OFF_W-1:0]),
        .size    (strb_size_s),
        .strb    (strb_s)
    );

    // Sequencer FSM with registered beat descriptor.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            mode_r      <= FIXED;
            size_r      <= {SIZE{1'b0}};
            len_r       <= {LEN_W{1'b0}};
            cnt_r       <= {LEN_W{1'b0}};
            wrap_low_r  <= {WIDTH{1'b0}};
            wrap_high_r <= {WIDTH{1'b0}};
            beat_valid  <= 1'b0;
            beat_addr   <= {WIDTH{1'b0}};
            beat_strb   <= {STRB_W{1'b0}};
            beat_last   <= 1'b0;
            beat_id     <= {LEN_W{1'b0}};
            beat_err    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state_r     <= BURST;
                        // Illegal commands still run their beats, at a fixed address.
                        mode_r      <= err_s ? FIXED : burst_s;
                        size_r      <= cmd_size;
                        len_r       <= cmd_len;
                        cnt_r       <= {LEN_W{1'b0}};
                        wrap_low_r  <= cmd_addr & ~(span_cmd_s - {{(WIDTH-1){1'b0}}, 1'b1});
                        wrap_high_r <= (cmd_addr & ~(span_cmd_s - {{(WIDTH-1){1'b0}}, 1'b1})) + span_cmd_s;
                        beat_valid  <= 1'b1;
                        beat_addr   <= cmd_addr;
                        beat_strb   <= strb_s;
                        beat_last   <= (cmd_len == {LEN_W{1'b0}});
                        beat_id     <= cmd_id;
                        beat_err    <= err_s;
                    end else begin
                        beat_valid  <= 1'b0;
                    end
                end
                BURST: begin
                    if (beat_valid && beat_ready) begin
                        if (beat_last) begin
                            state_r    <= IDLE;
                            beat_valid <= 1'b0;
                            beat_last  <= 1'b0;
                        end else begin
                            cnt_r      <= cnt_r + LEN_W'(1);
                            beat_addr  <= next_addr_s;
                            beat_strb  <= strb_s;
                            beat_last  <= ((cnt_r + LEN_W'(1)) == len_r);
                        end
                    end else begin
                        beat_valid <= beat_valid;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    beat_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_axi_burst_addr_gen
// Directed stimulus with hand-computed beat descriptors pushed into a
// scoreboard queue; a monitor pops and compares on every beat handshake.
// ---------------------------------------------------------------------------
module tb_axi_burst_addr_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [3:0]  cmd_id;
    logic        beat_valid;
    logic        beat_ready;
    logic [31:0] beat_addr;
    logic [3:0]  beat_strb;
    logic        beat_last;
    logic [3:0]  beat_id;
    logic        beat_err;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic        last;
        logic [3:0]  id;
        logic        err;
    } beat_t;

    beat_t       exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [3:0]  cur_id;

    always #5 clk = ~clk;

    axi_burst_addr_gen #(.WIDTH(32), .SIZE(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_size   (cmd_size),
        .cmd_burst  (cmd_burst),
        .cmd_id     (cmd_id),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_addr  (beat_addr),
        .beat_strb  (beat_strb),
        .beat_last  (beat_last),
        .beat_id    (beat_id),
        .beat_err   (beat_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic exp_beat(input logic [31:0] addr, input logic [3:0] strb,
                            input logic last, input logic err);
        beat_t b;
        b.addr = addr;
        b.strb = strb;
        b.last = last;
        b.id   = cur_id;
        b.err  = err;
        exp_q.push_back(b);
    endtask

    // Scoreboard monitor: compare each accepted beat against the queue head.
    always @(negedge clk) begin : monitor
        beat_t got;
        beat_t want;
        if (!reset && beat_valid && beat_ready) begin
            got.addr = beat_addr;
            got.strb = beat_strb;
            got.last = beat_last;
            got.id   = beat_id;
            got.err  = beat_err;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat actual addr=%h strb=%b last=%b id=%h err=%b required none",
                         got.addr, got.strb, got.last, got.id, got.err);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL beat actual addr=%h strb=%b last=%b id=%h err=%b required addr=%h strb=%b last=%b id=%h err=%b",
                             got.addr, got.strb, got.last, got.id, got.err,
                             want.addr, want.strb, want.last, want.id, want.err);
                end
            end
        end
    end

    // Present a command, wait for accept, check first-beat latency.
    task automatic issue(input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n;
        @(posedge clk);
        #1;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_size  = size;
        cmd_burst = burst;
        cmd_id    = cur_id;
        cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("first_beat_valid", {31'd0, beat_valid}, 32'd1);
        chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || beat_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_addr   = 32'd0;
        cmd_len    = 4'd0;
        cmd_size   = 3'd0;
        cmd_burst  = 2'd0;
        cmd_id     = 4'd0;
        beat_ready = 1'b1;
        cur_id     = 4'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_beat_valid", {31'd0, beat_valid}, 32'd0);
        chk("rst_cmd_ready",  {31'd0, cmd_ready},  32'd0);
        chk("rst_beat_addr",  beat_addr, 32'd0);
        chk("rst_beat_misc",  {24'd0, beat_strb, beat_id}, 32'd0);
        chk("rst_last_err",   {30'd0, beat_last, beat_err}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        // INCR aligned
        cur_id = 4'h1;
        exp_beat(32'h100, 4'b1111, 1'b0, 1'b0);
        exp_beat(32'h104, 4'b1111, 1'b0, 1'b0);
        exp_beat(32'h108, 4'b1111, 1'b0, 1'b0);
        exp_beat(32'h10C, 4'b1111, 1'b1, 1'b0);
        issue(32'h100, 4'd3, 3'd2, 2'b01);
        drain();

        // WRAP
        cur_id = 4'h2;
        exp_beat(32'h38, 4'b1111, 1'b0, 1'b0);
        exp_beat(32'h3C, 4'b1111, 1'b0, 1'b0);
        exp_beat(32'h30, 4'b1111, 1'b0, 1'b0);
        exp_beat(32'h34, 4'b1111, 1'b1, 1'b0);
        issue(32'h38, 4'd3, 3'd2, 2'b10);
        drain();

        // FIXED halfword
        cur_id = 4'h3;
        exp_beat(32'h20, 4'b0011, 1'b0, 1'b0);
        exp_beat(32'h20, 4'b0011, 1'b0, 1'b0);
        exp_beat(32'h20, 4'b0011, 1'b1, 1'b0);
        issue(32'h20, 4'd2, 3'd1, 2'b00);
        drain();

        // INCR unaligned start
        cur_id = 4'h4;
        exp_beat(32'h101, 4'b1110, 1'b0, 1'b0);
        exp_beat(32'h104, 4'b1111, 1'b1, 1'b0);
        issue(32'h101, 4'd1, 3'd2, 2'b01);
        drain();

        // Single byte beat, len 0
        cur_id = 4'h5;
        exp_beat(32'h303, 4'b1000, 1'b1, 1'b0);
        issue(32'h303, 4'd0, 3'd0, 2'b01);
        drain();

        // Backpressure hold, then reset mid-burst
        cur_id = 4'h6;
        exp_beat(32'h200, 4'b1111, 1'b0, 1'b0);
        exp_beat(32'h204, 4'b1111, 1'b0, 1'b0);
        issue(32'h200, 4'd3, 3'd2, 2'b01);
        @(posedge clk);
        #1;
        beat_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, beat_valid}, 32'd1);
            chk("hold_addr", beat_addr, 32'h204);
            chk("hold_strb_last", {27'd0, beat_strb, beat_last}, {27'd0, 4'b1111, 1'b0});
        end
        @(posedge clk);
        #1;
        beat_ready = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b1;
        beat_ready = 1'b0;
        @(negedge clk);
        chk("beat3_addr", beat_addr, 32'h208);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_abandon_valid", {31'd0, beat_valid}, 32'd0);
        chk("ready_after_release", {31'd0, cmd_ready}, 32'd1);
        chk("reset_queue_empty", exp_q.size(), 32'd0);
        beat_ready = 1'b1;

        // Reserved burst
        cur_id = 4'h7;
        exp_beat(32'h40, 4'b1111, 1'b0, 1'b1);
        exp_beat(32'h40, 4'b1111, 1'b1, 1'b1);
        issue(32'h40, 4'd1, 3'd2, 2'b11);
        drain();

        // WRAP with illegal length
        cur_id = 4'h8;
        exp_beat(32'h10, 4'b1111, 1'b0, 1'b1);
        exp_beat(32'h10, 4'b1111, 1'b0, 1'b1);
        exp_beat(32'h10, 4'b1111, 1'b1, 1'b1);
        issue(32'h10, 4'd2, 3'd2, 2'b10);
        drain();

        // Oversized beat
        cur_id = 4'h9;
        exp_beat(32'h50, 4'b1111, 1'b0, 1'b1);
        exp_beat(32'h50, 4'b1111, 1'b1, 1'b1);
        issue(32'h50, 4'd1, 3'd3, 2'b01);
        drain();

        // WRAP unaligned start
        cur_id = 4'hA;
        exp_beat(32'h32, 4'b1100, 1'b0, 1'b1);
        exp_beat(32'h32, 4'b1100, 1'b1, 1'b1);
        issue(32'h32, 4'd1, 3'd2, 2'b10);
        drain();

        // 4 KB crossing and top-of-space wrap
        cur_id = 4'hB;
`ifdef AXI_4K_CHECK_EN
        exp_beat(32'hFF8, 4'b1111, 1'b0, 1'b1);
        exp_beat(32'hFF8, 4'b1111, 1'b0, 1'b1);
        exp_beat(32'hFF8, 4'b1111, 1'b0, 1'b1);
        exp_beat(32'hFF8, 4'b1111, 1'b1, 1'b1);
`else
        exp_beat(32'hFF8,  4'b1111, 1'b0, 1'b0);
        exp_beat(32'hFFC,  4'b1111, 1'b0, 1'b0);
        exp_beat(32'h1000, 4'b1111, 1'b0, 1'b0);
        exp_beat(32'h1004, 4'b1111, 1'b1, 1'b0);
`endif
        issue(32'hFF8, 4'd3, 3'd2, 2'b01);
        drain();

        cur_id = 4'hC;
`ifdef AXI_4K_CHECK_EN
        exp_beat(32'hFFFF_FFFC, 4'b1111, 1'b0, 1'b1);
        exp_beat(32'hFFFF_FFFC, 4'b1111, 1'b1, 1'b1);
`else
        exp_beat(32'hFFFF_FFFC, 4'b1111, 1'b0, 1'b0);
        exp_beat(32'h0000_0000, 4'b1111, 1'b1, 1'b0);
`endif
        issue(32'hFFFF_FFFC, 4'd1, 3'd2, 2'b01);
        drain();

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
